// File: rtl/mem_pkg.sv
// Shared types and helpers for the segmented byte-banked memory.
// Holds the request-size and data-FSM encodings plus the region-membership test.
package mem_pkg;

  typedef enum logic {SZ_BYTE = 1'b0, SZ_HALF = 1'b1} size_t;

  typedef enum logic {IDLE = 1'b0, HI = 1'b1} dstate_t;

  // True when byte address a falls inside region r of a segment built from depth-byte regions.
  function automatic logic region_hit(input int unsigned a, input int unsigned r,
                                      input int unsigned depth);
    return (a >= r * depth) && (a < (r + 1) * depth);
  endfunction

endpackage

// File: rtl/byte_bank.sv
// Single-port byte RAM: synchronous write, registered read (read-before-write on a shared address).
module byte_bank #(
  parameter  int DEPTH = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // NOTE: the array and its read register are deliberately not reset; a RAM cannot be cleared
  // in one cycle, so the parent gates writes with reset and masks the read data instead.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/banked_mem.sv
// Instruction segment (byte lanes sharing one index) and data segment (contiguous byte regions)
// with a valid/ready data port; halfword data accesses run as two sequenced byte operations.
module banked_mem
  import mem_pkg::*;
#(
  parameter int WIDTH            = 16,
  parameter int INSTRUCTIONWIDTH = 24,
  parameter int IDEPTH           = 4,
  parameter int DBANKS           = 3,
  parameter int DEPTH            = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [WIDTH-1:0]            i_addr,
  input  logic                        i_we,
  input  logic [INSTRUCTIONWIDTH-1:0] i_wdata,
  output logic [INSTRUCTIONWIDTH-1:0] i_rdata,
  output logic                        i_err,
  input  logic                        d_valid,
  output logic                        d_ready,
  input  logic                        d_we,
  input  logic                        d_size,
  input  logic [WIDTH-1:0]            d_addr,
  input  logic [WIDTH-1:0]            d_wdata,
  output logic                        d_rvalid,
  output logic [WIDTH-1:0]            d_rdata,
  output logic                        d_err
);

  localparam int          ILANES = INSTRUCTIONWIDTH / 8;
  localparam int          IAW    = (IDEPTH > 1) ? $clog2(IDEPTH) : 1;
  localparam int          DAW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          RW     = (DBANKS > 1) ? $clog2(DBANKS) : 1;
  localparam int unsigned DLIMIT = DBANKS * DEPTH;

  // ---------------- instruction segment ----------------
  logic       i_in;
  logic       i_ok_q;
  logic [7:0] ilane_rd [ILANES];

  assign i_in = 32'(i_addr) < IDEPTH;

  for (genvar k = 0; k < ILANES; k++) begin : g_ilane
    byte_bank #(.DEPTH(IDEPTH)) u_lane (
      .clk   (clk),
      .we    (rst_n && i_we && i_in),
      .addr  (i_addr[IAW-1:0]),
      .wdata (i_wdata[INSTRUCTIONWIDTH-1-8*k -: 8]),
      .rdata (ilane_rd[k])
    );
    // Lane 0 is the most significant byte; out-of-range fetches and reset force zero.
    assign i_rdata[INSTRUCTIONWIDTH-1-8*k -: 8] = i_ok_q ? ilane_rd[k] : 8'h00;
  end

  // NOTE: every clocked block uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i_ok_q <= 1'b0;
      i_err  <= 1'b0;
    end else begin
      i_ok_q <= i_in;
      i_err  <= !i_in;
    end
  end

  // ---------------- data segment ----------------
  dstate_t          state;
  logic [WIDTH-1:0] hi_addr_q;
  logic             we_q, rd_q, half_q, rv_q, err_q;
  logic [7:0]       whi_q, lo_q, sel_rd;
  logic [RW-1:0]    rsel_q, op_region;
  logic             accept, acc_half, acc_err;
  logic [WIDTH-1:0] op_addr;
  logic             op_we, op_en;
  logic [7:0]       op_wdata;
  logic [DBANKS-1:0] hit;
  logic [7:0]       dbank_rd [DBANKS];

  assign d_ready  = rst_n && (state == IDLE);
  assign accept   = d_valid && d_ready;
  assign acc_half = size_t'(d_size) == SZ_HALF;
  assign acc_err  = (32'(d_addr) + (acc_half ? 32'd1 : 32'd0)) >= DLIMIT;

  // The bank operation this edge: the live request in IDLE, the latched high byte in HI.
  // NOTE: every output is assigned on both branches, so no latch can be inferred.
  always_comb begin
    if (state == HI) begin
      op_addr  = hi_addr_q;
      op_we    = we_q;
      op_wdata = whi_q;
      op_en    = 1'b1;
    end else begin
      op_addr  = d_addr;
      op_we    = d_we;
      op_wdata = d_wdata[7:0];
      op_en    = accept && !acc_err;
    end
  end

  for (genvar r = 0; r < DBANKS; r++) begin : g_dbank
    assign hit[r] = region_hit(32'(op_addr), r, DEPTH);
    byte_bank #(.DEPTH(DEPTH)) u_bank (
      .clk   (clk),
      .we    (rst_n && op_en && op_we && hit[r]),
      .addr  (DAW'(op_addr - WIDTH'(r * DEPTH))),
      .wdata (op_wdata),
      .rdata (dbank_rd[r])
    );
  end

  always_comb begin
    op_region = '0;
    for (int r = 0; r < DBANKS; r++)
      if (hit[r]) op_region = RW'(r);
  end

  assign sel_rd = dbank_rd[rsel_q];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      rv_q   <= 1'b0;
      err_q  <= 1'b0;
      rd_q   <= 1'b0;
      half_q <= 1'b0;
    end else begin
      rv_q  <= 1'b0;
      err_q <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          if (acc_err) begin
            rv_q   <= 1'b1;
            err_q  <= 1'b1;
            rd_q   <= 1'b0;
            half_q <= 1'b0;
          end else if (acc_half) begin
            state     <= HI;
            hi_addr_q <= d_addr + WIDTH'(1);
            we_q      <= d_we;
            whi_q     <= d_wdata[15:8];
            rsel_q    <= op_region;
          end else begin
            rv_q   <= 1'b1;
            rd_q   <= !d_we;
            half_q <= 1'b0;
            rsel_q <= op_region;
          end
        end
        HI: begin
          // Low byte was read at the accept edge; keep it before its bank is reused.
          state  <= IDLE;
          rv_q   <= 1'b1;
          rd_q   <= !we_q;
          half_q <= 1'b1;
          lo_q   <= sel_rd;
          rsel_q <= op_region;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    d_rdata = '0;
    if (rv_q && rd_q) d_rdata[15:0] = half_q ? {sel_rd, lo_q} : {8'h00, sel_rd};
  end

  assign d_rvalid = rv_q;
  assign d_err    = err_q;

endmodule
